rf_wb_queue: RTL and testbench
==============================

# rf_wb_queue

Write-side companion of the 32×32 register file: collects writeback requests from the single-cycle ALU path and the variable-latency load path. Requests are buffered in a small in-order queue and drained one per cycle onto the register file's single write port (`WriteReg`/`WD`/`RorW`). The block also exports a pending-write hazard flag that decode uses to stall reads of registers whose writes are still queued.

## Interface
- `DEPTH`, 4: queue entries; must be a power of two, at least 2.
- `AW`, 5: register address width.
- `DW`, 32: data width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ld_valid`  in  1  load writeback request.
- `ld_reg`  in  AW  load destination register.
- `ld_data`  in  DW  load result.
- `ld_ready`  out  1  load request accepted this cycle when high together with `ld_valid`.
- `alu_valid`  in  1  ALU writeback request.
- `alu_reg`  in  AW  ALU destination register.
- `alu_data`  in  DW  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle when high together with `alu_valid`.
- `WriteReg`  out  AW  register-file write address (head entry).
- `WD`  out  DW  register-file write data (head entry).
- `RorW`  out  1  register-file write enable; high when the queue is non-empty.
- `chk_a1`, `chk_a2`  in  AW  decode read addresses to check.
- `hazard`  out  1  a queued entry targets a nonzero `chk_a1` or `chk_a2`.

## Operation
- State: `DEPTH` entries of {reg, data}, head/tail pointers, and an occupancy `count` (0..DEPTH). `free = DEPTH - count` uses registered `count` only; a same-cycle pop does not create space.
- Ready:
  - `ld_ready = (free >= 1)`.
  - `alu_ready = (free >= 2)` when `ld_valid` is high; otherwise `alu_ready = (free >= 1)`.
  - The load path has priority.
- Push:
  - Accepted load is written at tail, then accepted ALU at tail+1, so at most two pushes per cycle.
  - When both are accepted in the same cycle, the load is ordered ahead of the ALU request.
- Register 0:
  - A request with reg==0 is accepted (ready per the rules above) but not enqueued and does not consume a slot.
  - For `alu_ready`, an `ld_valid` with `ld_reg==0` still counts as a pending load.
- Pop:
  - When `count>0`, the head drives `WriteReg`/`WD` with `RorW=1`.
  - The register file always accepts, so the head is popped at every edge where `count>0`.
  - When empty: `RorW=0`, `WriteReg=0`, `WD=0`.
- Count update: `count_next = count + pushes - pop`, where pushes is 0..2 and pop is 0..1. This never exceeds `DEPTH`, by construction of the ready rules.
- Ordering: strict FIFO. Two writes to the same register reach the register file in acceptance order, and the last one wins.
- Hazard:
  - `hazard` is combinational: OR over all occupied entries (including the head currently on the write port) of (entry.reg == chk_a1 && chk_a1 != 0) || (entry.reg == chk_a2 && chk_a2 != 0).
  - Requests being pushed this cycle are not included.
  - Same-cycle producer-to-consumer forwarding is not this block's job.
- Pointers wrap modulo `DEPTH`.

## Timing
- Request accepted at edge N is in the queue after edge N. It appears on `WriteReg`/`WD`/`RorW` in cycle N+k, where k is the number of entries ahead of it plus 1. With an empty queue it is written into the register file at edge N+1.
- Throughput: one register-file write per cycle; sustained input of two per cycle back-pressures.
- Reset values: `count=0`, pointers 0, `RorW=0`, `WriteReg=0`, `WD=0`, `hazard=0`.
- Ready with no valids: `ld_ready=1` and `alu_ready=1` (free = `DEPTH`).
- Reset asserted mid-operation drops all queued entries. Outputs go to reset values asynchronously; no register-file write occurs at the next edge.

## Structure
- Package `rf_wb_pkg`: `AW`/`DW` constants and the `rf_wb_entry_t` typedef {reg [AW-1:0], data [DW-1:0]}.
- One sub-module: `rf_wb_fifo`, a 2-push/1-pop circular buffer exposing `count`, the head entry, and a per-entry valid vector for the hazard compare.
- Top level holds the ready logic, the reg-0 filter and the hazard comparators.

## Test plan
- Single ALU write: after reset, `alu_valid=1` with reg 5 / data 0xDEADBEEF for one cycle. Required: next cycle `RorW=1`, `WriteReg=5`, `WD=0xDEADBEEF`; the cycle after, `RorW=0`.
- Dual push order: `ld` reg 3 / 0x11 and `alu` reg 3 / 0x22 in the same cycle. Required: writes emitted in order 0x11 then 0x22 on consecutive cycles; `hazard=1` for `chk_a1=3` until the second write leaves the queue.
- Full back-pressure: hold both valids high with distinct regs for 4 cycles. Required:
  - `alu_ready` drops once free < 2 with `ld_valid` high, and `ld_ready` drops at free = 0.
  - `count` never exceeds 4.
  - Exactly one write per cycle, in order.
- Register 0: `alu_valid` with reg 0 / 0xFFFF. Required: `alu_ready=1`, `RorW` stays 0, `count` unchanged; `hazard=0` for `chk_a1=0`, even with entries queued.
- Reset mid-queue: fill 3 entries, assert `reset` between edges. Required: `RorW`, `WriteReg`, `WD` and `hazard` go to 0 immediately; after deassert, no stale writes appear.

Source files
------------

// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_pkg
// Brief    : Shared widths and queue entry type for the register-file
//            writeback queue.
// Revision : 1.0
// ============================================================================
package rf_wb_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    // "reg" is a keyword, so the destination register field is named addr.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rf_wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_fifo
// Brief    : 2-push / 1-pop circular buffer; pops the head whenever non-empty.
// Revision : 1.0
// ============================================================================
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr0_en,
    input  rf_wb_entry_t                 i_wr0,
    input  logic                         i_wr1_en,
    input  rf_wb_entry_t                 i_wr1,
    output logic [CW-1:0]                o_count,
    output rf_wb_entry_t                 o_head,
    output rf_wb_entry_t [DEPTH-1:0]     o_entries,
    output logic [DEPTH-1:0]             o_valid
);

    rf_wb_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_tail;
    logic [CW-1:0]            r_count;
    logic [PW-1:0]            w_tail1;
    logic                     w_pop;

    assign w_pop   = (r_count != '0);
    assign w_tail1 = r_tail + PW'(1);

    // i_wr1 is only ever used together with i_wr0, so it lands one past the tail.
    always_ff @(posedge clk) begin
        if (i_wr0_en) begin
            r_mem[r_tail] <= i_wr0;
        end
        if (i_wr1_en) begin
            r_mem[w_tail1] <= i_wr1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PW'(i_wr0_en) + PW'(i_wr1_en);
            r_head  <= r_head + PW'(w_pop);
            r_count <= r_count + CW'(i_wr0_en) + CW'(i_wr1_en) - CW'(w_pop);
        end
    end

    assign o_count   = r_count;
    assign o_head    = r_mem[r_head];
    assign o_entries = r_mem;

    // A slot is occupied when its distance from the head is below the count.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_valid
            logic [PW-1:0] w_off;
            assign w_off      = PW'(i) - r_head;
            assign o_valid[i] = ({1'b0, w_off} < r_count);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_queue
// Brief    : Merges load and ALU writebacks into an in-order queue drained onto
//            the register file write port; flags reads of pending registers.
// Revision : 1.0
// ============================================================================
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = rf_wb_pkg::AW,
    parameter int DW    = rf_wb_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_reg,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    output logic [AW-1:0] WriteReg,
    output logic [DW-1:0] WD,
    output logic          RorW,
    input  logic [AW-1:0] chk_a1,
    input  logic [AW-1:0] chk_a2,
    output logic          hazard
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]            w_count;
    logic [CW-1:0]            w_free;
    logic                     w_ld_push;
    logic                     w_alu_push;
    rf_wb_entry_t             w_ld_ent;
    rf_wb_entry_t             w_alu_ent;
    rf_wb_entry_t             w_wr0;
    rf_wb_entry_t             w_head;
    rf_wb_entry_t [DEPTH-1:0] w_entries;
    logic [DEPTH-1:0]         w_valid;
    logic                     w_hazard;

    // Space is judged on registered occupancy only; the pop this cycle does not count.
    assign w_free    = CW'(DEPTH) - w_count;
    assign ld_ready  = (w_free != '0);
    assign alu_ready = ld_valid ? (w_free >= CW'(2)) : (w_free != '0);

    // Writes to r0 are acknowledged but dropped, and never take a slot.
    assign w_ld_push  = ld_valid  & ld_ready  & (ld_reg  != '0);
    assign w_alu_push = alu_valid & alu_ready & (alu_reg != '0);

    assign w_ld_ent  = '{addr: ld_reg,  data: ld_data};
    assign w_alu_ent = '{addr: alu_reg, data: alu_data};
    assign w_wr0     = w_ld_push ? w_ld_ent : w_alu_ent;

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr0_en  (w_ld_push | w_alu_push),
        .i_wr0     (w_wr0),
        .i_wr1_en  (w_ld_push & w_alu_push),
        .i_wr1     (w_alu_ent),
        .o_count   (w_count),
        .o_head    (w_head),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    assign RorW     = (w_count != '0);
    assign WriteReg = RorW ? w_head.addr : '0;
    assign WD       = RorW ? w_head.data : '0;

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] &&
                (((w_entries[i].addr == chk_a1) && (chk_a1 != '0)) ||
                 ((w_entries[i].addr == chk_a2) && (chk_a2 != '0)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign hazard = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_queue
// Brief    : Scoreboard bench for rf_wb_queue against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_rf_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic [4:0]  WriteReg;
    logic [31:0] WD;
    logic        RorW;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic        hazard;

    int   n_vec;
    int   n_err;
    ent_t exp_q[$];
    logic p_ld;
    logic p_alu;
    ent_t p_ld_e;
    ent_t p_alu_e;
    ent_t mon_e;

    rf_wb_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_reg    (ld_reg),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .WriteReg  (WriteReg),
        .WD        (WD),
        .RorW      (RorW),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .hazard    (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock cycle: commit last cycle's accepted requests to the model,
    // drive new inputs, then check ready/hazard against the model contents.
    task automatic cycle(input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic [4:0] c1, input logic [4:0] c2);
        int   free;
        logic e_ldr;
        logic e_alur;
        logic e_haz;
        @(posedge clk);
        #1;
        if (p_ld)  exp_q.push_back(p_ld_e);
        if (p_alu) exp_q.push_back(p_alu_e);
        check("model_occupancy", 64'(exp_q.size() > DEPTH), 64'(0));
        ld_valid  = lv;
        ld_reg    = lr;
        ld_data   = ldd;
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        chk_a1    = c1;
        chk_a2    = c2;
        #1;
        free   = DEPTH - exp_q.size();
        e_ldr  = (free >= 1);
        e_alur = lv ? (free >= 2) : (free >= 1);
        e_haz  = 1'b0;
        foreach (exp_q[i]) begin
            if ((exp_q[i].r == c1 && c1 != 0) || (exp_q[i].r == c2 && c2 != 0)) e_haz = 1'b1;
        end
        check("ld_ready", 64'(ld_ready), 64'(e_ldr));
        check("alu_ready", 64'(alu_ready), 64'(e_alur));
        check("hazard", 64'(hazard), 64'(e_haz));
        p_ld    = lv && e_ldr && (lr != 0);
        p_alu   = av && e_alur && (ar != 0);
        p_ld_e  = '{r: lr, d: ldd};
        p_alu_e = '{r: ar, d: ad};
    endtask

    task automatic idle(input int n, input logic [4:0] c1);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, c1, 0);
    endtask

    task automatic reset_mid();
        #1;
        reset     = 1'b1;
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        p_ld      = 1'b0;
        p_alu     = 1'b0;
        exp_q.delete();
        #1;
        check("rst_RorW", 64'(RorW), 64'(0));
        check("rst_WriteReg", 64'(WriteReg), 64'(0));
        check("rst_WD", 64'(WD), 64'(0));
        check("rst_hazard", 64'(hazard), 64'(0));
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: every presented write must be the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (RorW) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'(0), WriteReg, WD}, 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("WriteReg", 64'(WriteReg), 64'(mon_e.r));
                    check("WD", 64'(WD), 64'(mon_e.d));
                end
            end else begin
                check("idle_pending", 64'(exp_q.size()), 64'(0));
                check("idle_bus", {27'(0), WriteReg, WD}, 64'(0));
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        p_ld      = 1'b0;
        p_alu     = 1'b0;
        reset     = 1'b1;
        ld_valid  = 1'b0;
        ld_reg    = '0;
        ld_data   = '0;
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        chk_a1    = '0;
        chk_a2    = '0;
        #12;
        check("reset_RorW", 64'(RorW), 64'(0));
        check("reset_WriteReg", 64'(WriteReg), 64'(0));
        check("reset_WD", 64'(WD), 64'(0));
        check("reset_hazard", 64'(hazard), 64'(0));
        check("reset_ld_ready", 64'(ld_ready), 64'(1));
        check("reset_alu_ready", 64'(alu_ready), 64'(1));
        #1 reset = 1'b0;

        // Single ALU write
        cycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        idle(3, 5);

        // Dual push to the same register, load first
        cycle(1, 3, 32'h11, 1, 3, 32'h22, 3, 0);
        idle(4, 3);

        // Sustained dual input to exercise back-pressure
        for (int k = 0; k < 6; k++) cycle(1, 5'(8 + k), $urandom, 1, 5'(16 + k), $urandom, 8, 17);
        idle(6, 9);

        // Register 0 requests, alone and alongside a real write
        cycle(0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        cycle(1, 9, 32'h99, 1, 0, 32'hFFFF, 0, 9);
        idle(3, 0);

        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(DEPTH + 2, 0);

        // Reset with three entries queued
        cycle(1, 1, 32'hA1, 1, 2, 32'hA2, 0, 0);
        cycle(1, 4, 32'hA4, 1, 6, 32'hA6, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 4, 6);
        reset_mid();
        idle(4, 4);

        for (int k = 0; k < 100; k++) begin
            cycle(($urandom_range(0, 99) < 70), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 99) < 70), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(DEPTH + 4, 0);
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
